// File: rtl/aer_out_ctrl.sv
// AER output controller: runs one 4-phase REQ/ACK handshake off chip per encoder event.
// Optional feature macro AER_ACK_TIMEOUT_EN aborts a handshake whose ACK edge is late.
module aer_out_ctrl #(
    parameter int ACK_SYNC_STAGES = 2,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [9:0]  AERIN_ADDR,
    input  logic        AERIN_VALID,
    output logic        AERIN_CTRL_BUSY,
    output logic [9:0]  AER_ADDR,
    output logic        AER_REQ,
    input  logic        AER_ACK,
    output logic [15:0] EVENT_COUNT,
    output logic        OVERRUN,
    output logic        TIMEOUT_ERR
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SETUP,
        WAIT_ACK_H,
        WAIT_ACK_L
    } state_t;

    state_t state;
    state_t state_next;

    logic [ACK_SYNC_STAGES-1:0] ack_sync;
    logic ack_s;
    logic done;
    logic timeout;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[ACK_SYNC_STAGES-2:0], AER_ACK};
        end
    end

    assign ack_s = ack_sync[ACK_SYNC_STAGES-1];

    always_comb begin
        state_next = state;
        done       = 1'b0;
        unique case (state)
            IDLE:       if (AERIN_VALID) state_next = CAPTURE;
            CAPTURE:    state_next = SETUP;
            SETUP:      state_next = WAIT_ACK_H;
            WAIT_ACK_H: begin
                if (ack_s) begin
                    state_next = WAIT_ACK_L;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            WAIT_ACK_L: begin
                if (!ack_s) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            default:    state_next = IDLE;
        endcase
    end

    // BUSY and REQ are registered copies of the next state, so they change on the same edge as it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state           <= IDLE;
            AERIN_CTRL_BUSY <= 1'b0;
            AER_REQ         <= 1'b0;
            AER_ADDR        <= 10'h000;
            EVENT_COUNT     <= 16'h0000;
            OVERRUN         <= 1'b0;
        end else begin
            state           <= state_next;
            AERIN_CTRL_BUSY <= (state_next != IDLE);
            AER_REQ         <= (state_next == WAIT_ACK_H);
            if (state == CAPTURE) begin
                AER_ADDR <= AERIN_ADDR;
            end
            if (done) begin
                EVENT_COUNT <= EVENT_COUNT + 16'd1;
            end
            if (AERIN_VALID && (state != IDLE)) begin
                OVERRUN <= 1'b1;
            end
        end
    end

`ifdef AER_ACK_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] wait_count;
    logic in_wait;
    logic entering_wait;
    logic abort;

    assign in_wait       = (state == WAIT_ACK_H) || (state == WAIT_ACK_L);
    assign entering_wait = (state_next != state) &&
                           ((state_next == WAIT_ACK_H) || (state_next == WAIT_ACK_L));
    assign timeout       = in_wait && (wait_count == TIMEOUT_LIMIT);
    // A completing ACK edge wins over a timeout that expires on the same edge.
    assign abort         = timeout && (state_next == IDLE) && !done;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_count  <= 8'h00;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            if (entering_wait) begin
                wait_count <= 8'h00;
            end else if (in_wait) begin
                wait_count <= wait_count + 8'd1;
            end
            if (abort) begin
                TIMEOUT_ERR <= 1'b1;
            end
        end
    end
`else
    assign timeout     = 1'b0;
    // Constant 0 for every legal TIMEOUT_CYCLES (1..255).
    assign TIMEOUT_ERR = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_aer_out_ctrl.sv
// Self-checking bench for aer_out_ctrl: directed scenarios plus randomized handshakes
// compared against a transaction-level model (event count, sticky flags, captured address).
module tb_aer_out_ctrl;

    localparam int STAGES   = 2;
    localparam int TIMEOUT  = 10;
    // ACK driven just after an edge: one edge to enter the chain, STAGES-1 to reach ack_s, one for the FSM.
    localparam int ACK_LAT  = STAGES + 1;
    localparam int LIMIT    = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  aerin_addr = '0;
    logic        aerin_valid = 1'b0;
    logic        aerin_ctrl_busy;
    logic [9:0]  aer_addr;
    logic        aer_req;
    logic        aer_ack = 1'b0;
    logic [15:0] event_count;
    logic        overrun;
    logic        timeout_err;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] model_count;
    logic        model_overrun;
    logic        model_terr;

    logic       hs_busy_e0, hs_req_e1, hs_req_e2, hs_busy_post;
    logic [9:0] hs_addr_e1, hs_addr_end;
    int         hs_req_fall, hs_busy_fall;

    aer_out_ctrl #(
        .ACK_SYNC_STAGES(STAGES),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLK            (clk),
        .RST            (rst),
        .AERIN_ADDR     (aerin_addr),
        .AERIN_VALID    (aerin_valid),
        .AERIN_CTRL_BUSY(aerin_ctrl_busy),
        .AER_ADDR       (aer_addr),
        .AER_REQ        (aer_req),
        .AER_ACK        (aer_ack),
        .EVENT_COUNT    (event_count),
        .OVERRUN        (overrun),
        .TIMEOUT_ERR    (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        aerin_valid = 1'b0;
        aer_ack = 1'b0;
        tick();
        rst = 1'b0;
        model_count = '0;
        model_overrun = 1'b0;
        model_terr = 1'b0;
        tick();
    endtask

    // Acts as encoder and off-chip receiver for one event; returns observations only.
    task automatic run_handshake(input logic [9:0] addr, input int dly_h, input int dly_l,
                                 input int extra_at, input logic [9:0] extra_addr,
                                 input bit end_strobe);
        aerin_addr = 10'($urandom);
        aerin_valid = 1'b1;
        tick();
        aerin_valid = 1'b0;
        aerin_addr = addr;
        hs_busy_e0 = aerin_ctrl_busy;
        tick();
        aerin_addr = 10'($urandom);
        hs_req_e1 = aer_req;
        hs_addr_e1 = aer_addr;
        tick();
        hs_req_e2 = aer_req;
        for (int i = 0; i < dly_h; i++) begin
            if (i == extra_at) begin
                aerin_valid = 1'b1;
                aerin_addr = extra_addr;
            end
            tick();
            aerin_valid = 1'b0;
        end
        aer_ack = 1'b1;
        hs_req_fall = -1;
        for (int i = 1; i <= LIMIT; i++) begin
            tick();
            if (aer_req == 1'b0) begin
                hs_req_fall = i;
                break;
            end
        end
        for (int i = 0; i < dly_l; i++) tick();
        aer_ack = 1'b0;
        hs_busy_fall = -1;
        for (int i = 1; i <= LIMIT; i++) begin
            if (end_strobe && i == ACK_LAT) aerin_valid = 1'b1;
            tick();
            aerin_valid = 1'b0;
            if (aerin_ctrl_busy == 1'b0) begin
                hs_busy_fall = i;
                break;
            end
        end
        tick();
        hs_busy_post = aerin_ctrl_busy;
        hs_addr_end = aer_addr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++; if (aer_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset req: got %b expected 0", aer_req); end
        tests_run++; if (aerin_ctrl_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset busy: got %b expected 0", aerin_ctrl_busy); end
        tests_run++; if (aer_addr !== 10'h000) begin tests_failed++; $display("[TB] FAIL reset addr: got %h expected 000", aer_addr); end
        tests_run++; if (event_count !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset count: got %h expected 0000", event_count); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset overrun: got %b expected 0", overrun); end
        tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset timeout_err: got %b expected 0", timeout_err); end
        rst = 1'b0;
        model_count = '0;
        model_overrun = 1'b0;
        model_terr = 1'b0;
        tick();
    endtask

    task automatic test_normal();
        run_handshake(10'h0A5, 3, 3, -1, 10'h000, 1'b0);
        model_count++;
        tests_run++; if (hs_busy_e0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL normal busy_e0: got %b expected 1", hs_busy_e0); end
        tests_run++; if (hs_req_e1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL normal req_e1: got %b expected 0", hs_req_e1); end
        tests_run++; if (hs_addr_e1 !== 10'h0A5) begin tests_failed++; $display("[TB] FAIL normal addr_e1: got %h expected 0a5", hs_addr_e1); end
        tests_run++; if (hs_req_e2 !== 1'b1) begin tests_failed++; $display("[TB] FAIL normal req_e2: got %b expected 1", hs_req_e2); end
        tests_run++; if (hs_req_fall !== ACK_LAT) begin tests_failed++; $display("[TB] FAIL normal req_fall: got %0d expected %0d", hs_req_fall, ACK_LAT); end
        tests_run++; if (hs_busy_fall !== ACK_LAT) begin tests_failed++; $display("[TB] FAIL normal busy_fall: got %0d expected %0d", hs_busy_fall, ACK_LAT); end
        tests_run++; if (event_count !== model_count) begin tests_failed++; $display("[TB] FAIL normal count: got %0d expected %0d", event_count, model_count); end
    endtask

    task automatic test_encoder_seq();
        logic [9:0] seq [3];
        seq = '{10'h1FF, 10'h1FF, 10'h003};
        for (int k = 0; k < 3; k++) begin
            run_handshake(seq[k], 1, 1, -1, 10'h000, 1'b0);
            model_count++;
            tests_run++; if (hs_addr_end !== seq[k]) begin tests_failed++; $display("[TB] FAIL encseq addr[%0d]: got %h expected %h", k, hs_addr_end, seq[k]); end
        end
        tests_run++; if (event_count !== model_count) begin tests_failed++; $display("[TB] FAIL encseq count: got %0d expected %0d", event_count, model_count); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL encseq overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_early_ack();
        int cyc;
        aer_ack = 1'b1;
        for (int i = 0; i < STAGES + 1; i++) tick();
        aerin_valid = 1'b1;
        tick();
        aerin_valid = 1'b0;
        aerin_addr = 10'h2C7;
        tick();
        aerin_addr = 10'h000;
        tick();
        tests_run++; if (aer_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL early_ack req_e2: got %b expected 1", aer_req); end
        tick();
        tests_run++; if (aer_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL early_ack req_e3: got %b expected 0", aer_req); end
        aer_ack = 1'b0;
        cyc = -1;
        for (int i = 1; i <= LIMIT; i++) begin
            tick();
            if (!aerin_ctrl_busy) begin cyc = i; break; end
        end
        model_count++;
        tests_run++; if (cyc !== ACK_LAT) begin tests_failed++; $display("[TB] FAIL early_ack busy_fall: got %0d expected %0d", cyc, ACK_LAT); end
        tests_run++; if (aer_addr !== 10'h2C7) begin tests_failed++; $display("[TB] FAIL early_ack addr: got %h expected 2c7", aer_addr); end
        tests_run++; if (event_count !== model_count) begin tests_failed++; $display("[TB] FAIL early_ack count: got %0d expected %0d", event_count, model_count); end
    endtask

    task automatic test_overrun_at_return();
        do_reset();
        run_handshake(10'h1C2, 2, 2, -1, 10'h000, 1'b1);
        model_count++;
        model_overrun = 1'b1;
        tests_run++; if (hs_busy_post !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovr_return accepted: got busy %b expected 0", hs_busy_post); end
        tests_run++; if (overrun !== model_overrun) begin tests_failed++; $display("[TB] FAIL ovr_return overrun: got %b expected %b", overrun, model_overrun); end
        tests_run++; if (event_count !== model_count) begin tests_failed++; $display("[TB] FAIL ovr_return count: got %0d expected %0d", event_count, model_count); end
    endtask

    task automatic test_overrun();
        do_reset();
        run_handshake(10'h2AA, 4, 2, 1, 10'h055, 1'b0);
        model_count++;
        model_overrun = 1'b1;
        tests_run++; if (hs_addr_end !== 10'h2AA) begin tests_failed++; $display("[TB] FAIL overrun addr: got %h expected 2aa", hs_addr_end); end
        tests_run++; if (overrun !== model_overrun) begin tests_failed++; $display("[TB] FAIL overrun flag: got %b expected %b", overrun, model_overrun); end
        tests_run++; if (event_count !== model_count) begin tests_failed++; $display("[TB] FAIL overrun count: got %0d expected %0d", event_count, model_count); end
    endtask

    task automatic test_random();
        logic [9:0] addr;
        int dly_h, dly_l, extra_at;
        bit end_strobe;
        for (int n = 0; n < 20; n++) begin
            addr = 10'($urandom);
            dly_h = $urandom_range(0, 4);
            dly_l = $urandom_range(0, 4);
            extra_at = (dly_h > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, dly_h - 1) : -1;
            end_strobe = ($urandom_range(0, 3) == 0);
            run_handshake(addr, dly_h, dly_l, extra_at, 10'($urandom), end_strobe);
            model_count++;
            if (extra_at >= 0 || end_strobe) model_overrun = 1'b1;
            tests_run++; if (hs_busy_e0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL rand[%0d] busy_e0: got %b expected 1", n, hs_busy_e0); end
            tests_run++; if (hs_addr_e1 !== addr) begin tests_failed++; $display("[TB] FAIL rand[%0d] addr_e1: got %h expected %h", n, hs_addr_e1, addr); end
            tests_run++; if (hs_req_e2 !== 1'b1) begin tests_failed++; $display("[TB] FAIL rand[%0d] req_e2: got %b expected 1", n, hs_req_e2); end
            tests_run++; if (hs_req_fall !== ACK_LAT) begin tests_failed++; $display("[TB] FAIL rand[%0d] req_fall: got %0d expected %0d", n, hs_req_fall, ACK_LAT); end
            tests_run++; if (hs_busy_fall !== ACK_LAT) begin tests_failed++; $display("[TB] FAIL rand[%0d] busy_fall: got %0d expected %0d", n, hs_busy_fall, ACK_LAT); end
            tests_run++; if (hs_busy_post !== 1'b0) begin tests_failed++; $display("[TB] FAIL rand[%0d] busy_post: got %b expected 0", n, hs_busy_post); end
            tests_run++; if (hs_addr_end !== addr) begin tests_failed++; $display("[TB] FAIL rand[%0d] addr_hold: got %h expected %h", n, hs_addr_end, addr); end
            tests_run++; if (event_count !== model_count) begin tests_failed++; $display("[TB] FAIL rand[%0d] count: got %0d expected %0d", n, event_count, model_count); end
            tests_run++; if (overrun !== model_overrun) begin tests_failed++; $display("[TB] FAIL rand[%0d] overrun: got %b expected %b", n, overrun, model_overrun); end
        end
    endtask

    task automatic test_timeout();
        int cyc;
        aer_ack = 1'b0;
        aerin_valid = 1'b1;
        tick();
        aerin_valid = 1'b0;
        aerin_addr = 10'h3C3;
        tick();
        tick();
        tests_run++; if (aer_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout req_rise: got %b expected 1", aer_req); end
`ifdef AER_ACK_TIMEOUT_EN
        cyc = -1;
        for (int i = 1; i <= LIMIT; i++) begin
            tick();
            if (!aer_req) begin cyc = i; break; end
        end
        model_terr = 1'b1;
        tests_run++; if (cyc !== TIMEOUT + 1) begin tests_failed++; $display("[TB] FAIL timeout req_drop: got %0d expected %0d", cyc, TIMEOUT + 1); end
        tests_run++; if (aerin_ctrl_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout busy: got %b expected 0", aerin_ctrl_busy); end
`else
        for (int i = 0; i < 4 * TIMEOUT; i++) tick();
        tests_run++; if (aer_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL noto req_held: got %b expected 1", aer_req); end
        aer_ack = 1'b1;
        for (int i = 0; i < LIMIT && aer_req; i++) tick();
        aer_ack = 1'b0;
        cyc = -1;
        for (int i = 1; i <= LIMIT; i++) begin
            tick();
            if (!aerin_ctrl_busy) begin cyc = i; break; end
        end
        model_count++;
        tests_run++; if (cyc !== ACK_LAT) begin tests_failed++; $display("[TB] FAIL noto busy_fall: got %0d expected %0d", cyc, ACK_LAT); end
`endif
        tests_run++; if (timeout_err !== model_terr) begin tests_failed++; $display("[TB] FAIL timeout flag: got %b expected %b", timeout_err, model_terr); end
        tests_run++; if (event_count !== model_count) begin tests_failed++; $display("[TB] FAIL timeout count: got %0d expected %0d", event_count, model_count); end
        run_handshake(10'h12B, 1, 1, -1, 10'h000, 1'b0);
        model_count++;
        tests_run++; if (hs_busy_e0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout next_accept: got %b expected 1", hs_busy_e0); end
        tests_run++; if (event_count !== model_count) begin tests_failed++; $display("[TB] FAIL timeout next_count: got %0d expected %0d", event_count, model_count); end
    endtask

    task automatic test_wrap();
        force dut.EVENT_COUNT = 16'hFFFF;
        #1;
        release dut.EVENT_COUNT;
        model_count = 16'hFFFF;
        tests_run++; if (event_count !== model_count) begin tests_failed++; $display("[TB] FAIL wrap preload: got %h expected %h", event_count, model_count); end
        run_handshake(10'h301, 2, 2, -1, 10'h000, 1'b0);
        model_count++;
        tests_run++; if (event_count !== model_count) begin tests_failed++; $display("[TB] FAIL wrap count: got %h expected %h", event_count, model_count); end
    endtask

    task automatic test_reset_mid();
        aerin_valid = 1'b1;
        tick();
        aerin_valid = 1'b0;
        aerin_addr = 10'h0F0;
        tick();
        tick();
        aer_ack = 1'b1;
        for (int i = 0; i < LIMIT && aer_req; i++) tick();
        #2 rst = 1'b1;
        #1;
        tests_run++; if (aer_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_l req: got %b expected 0", aer_req); end
        tests_run++; if (aerin_ctrl_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_l busy: got %b expected 0", aerin_ctrl_busy); end
        tests_run++; if (event_count !== 16'h0000) begin tests_failed++; $display("[TB] FAIL rstmid_l count: got %h expected 0000", event_count); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_l overrun: got %b expected 0", overrun); end
        tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_l timeout_err: got %b expected 0", timeout_err); end
        tests_run++; if (aer_addr !== 10'h000) begin tests_failed++; $display("[TB] FAIL rstmid_l addr: got %h expected 000", aer_addr); end
        aer_ack = 1'b0;
        #1 rst = 1'b0;
        aerin_valid = 1'b1;
        tick();
        aerin_valid = 1'b0;
        tick();
        tick();
        tests_run++; if (aer_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_h req_before: got %b expected 1", aer_req); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (aer_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_h req: got %b expected 0", aer_req); end
        #1 rst = 1'b0;
        aerin_valid = 1'b1;
        tick();
        aerin_valid = 1'b0;
        tests_run++; if (aerin_ctrl_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid first_edge accept: got %b expected 1", aerin_ctrl_busy); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_encoder_seq();
        test_early_ack();
        test_overrun_at_return();
        test_overrun();
        test_random();
        test_timeout();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
